uart_host_master: RTL and testbench

//  Host-end counterpart of the board-side UART command path: serializes one

---
 rtl/uart_host_pkg.sv | 27 ++
 rtl/uart_rsp_deserializer.sv | 68 ++++++
 rtl/uart_host_master.sv | 145 ++++++++++++++
 tb/tb_uart_host_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// Shared constants and state encoding for the host-side UART request/response master.
package uart_host_pkg;

    localparam int PKT_BYTES = 12;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int PKT_W     = PKT_BYTES * BYTE_W;
    localparam int CNT_W     = 4;

    // Bit offsets of the three words inside a 96-bit packet (first word is most significant).
    localparam int W0_LSB       = 2 * WORD_W;
    localparam int W1_LSB       = WORD_W;
    localparam int W2_LSB       = 0;
    localparam int TOP_BYTE_LSB = PKT_W - BYTE_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_SEND  = 3'd1,
        ST_TX_GUARD = 3'd2,
        ST_TX_WAIT  = 3'd3,
        ST_RX       = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/uart_rsp_deserializer.sv
// Collects the response bytes into a 96-bit packet and flags completion or an
// inter-byte silence longer than the timeout.
module uart_rsp_deserializer
    import uart_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic             done,
    output logic             timeout,
    output logic [PKT_W-1:0] pkt
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PKT_W-1:0]   shift_q, shift_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        timer_d = timer_q;
        done    = 1'b0;
        timeout = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
            timer_d = '0;
        end else if (enable) begin
            if (rx_valid) begin
                shift_d = {shift_q[PKT_W-BYTE_W-1:0], rx_byte};
                cnt_d   = cnt_q + 1'b1;
                timer_d = '0;
                done    = (cnt_q == CNT_LAST);
            end else begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
                timeout = (timer_d == TIMER_LAST);
                done    = timeout;
            end
        end
    end

    // The top samples the packet on the same edge the last byte arrives.
    assign pkt = shift_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            timer_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/uart_host_master.sv
// Host-end UART command master: sends a 12-byte command/address/data packet and
// returns the 12-byte status/address/data response as three words.
//
// state    | meaning
// IDLE     | ready for a request, stray rx bytes dropped
// TX_SEND  | waiting for the core to go idle, then pulse transmit
// TX_GUARD | one cycle for the core to raise busy
// TX_WAIT  | waiting for the byte to finish, then advance
// RX       | collecting response bytes, watching inter-byte silence
// DONE     | one-cycle response strobe
module uart_host_master
    import uart_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en,
    input  logic [31:0] cmd_command,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic        rsp_timeout,
    output logic [31:0] rsp_status,
    output logic [31:0] rsp_address,
    output logic [31:0] rsp_data,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    input  logic        uart_tx_busy,
    input  logic        uart_received,
    input  logic [7:0]  uart_rx_byte
);

    state_e             state_q, state_d;
    logic [PKT_W-1:0]   tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [31:0]        rsp_status_q, rsp_status_d;
    logic [31:0]        rsp_address_q, rsp_address_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               rx_clear;
    logic               rx_done;
    logic               rx_timeout;
    logic [PKT_W-1:0]   rx_pkt;

    uart_rsp_deserializer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rsp_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (rx_clear),
        .enable   (state_q == ST_RX),
        .rx_valid (uart_received),
        .rx_byte  (uart_rx_byte),
        .done     (rx_done),
        .timeout  (rx_timeout),
        .pkt      (rx_pkt)
    );

    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        tx_cnt_d      = tx_cnt_q;
        rsp_status_d  = rsp_status_q;
        rsp_address_d = rsp_address_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        rx_clear      = 1'b0;
        uart_transmit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_en) begin
                    tx_shift_d = {cmd_command, cmd_address, cmd_data};
                    tx_cnt_d   = '0;
                    state_d    = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                if (!uart_tx_busy) begin
                    uart_transmit = 1'b1;
                    state_d       = ST_TX_GUARD;
                end
            end
            ST_TX_GUARD: state_d = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (!uart_tx_busy) begin
                    tx_shift_d = tx_shift_q << BYTE_W;
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_d = '0;
                        rx_clear = 1'b1;
                        state_d  = ST_RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        state_d  = ST_TX_SEND;
                    end
                end
            end
            ST_RX: begin
                if (rx_done) begin
                    state_d       = ST_DONE;
                    rsp_timeout_d = rx_timeout;
                    // A timed-out response leaves the previous words visible.
                    if (!rx_timeout) begin
                        rsp_status_d  = rx_pkt[W0_LSB +: WORD_W];
                        rsp_address_d = rx_pkt[W1_LSB +: WORD_W];
                        rsp_data_d    = rx_pkt[W2_LSB +: WORD_W];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            tx_shift_q    <= '0;
            tx_cnt_q      <= '0;
            rsp_status_q  <= '0;
            rsp_address_q <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            tx_cnt_q      <= tx_cnt_d;
            rsp_status_q  <= rsp_status_d;
            rsp_address_q <= rsp_address_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_DONE);
    assign rsp_timeout  = rsp_timeout_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_address  = rsp_address_q;
    assign rsp_data     = rsp_data_q;
    assign uart_tx_byte = tx_shift_q[TOP_BYTE_LSB +: BYTE_W];

endmodule

// File: tb/tb_uart_host_master.sv
// Self-checking bench for uart_host_master: table of transactions plus random
// ones, with a behavioural byte-level uart core and packet model.
module tb_uart_host_master;

    localparam int TMO    = 100;
    localparam int NBYTES = 12;
    localparam int TX_LEN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_en;
    logic [31:0] cmd_command, cmd_address, cmd_data;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_status, rsp_address, rsp_data;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_busy = 1'b0;
    logic        uart_received;
    logic [7:0]  uart_rx_byte;

    int n_pass = 0;
    int n_total = 0;

    int         busy_left = 0;
    logic       busy_hold = 1'b0;
    logic [7:0] tx_log[$];
    int         tx_overlap = 0;

    typedef struct {
        logic [31:0] c, a, d;
        logic [95:0] rx;
        int          n_rx;
        logic        noise;
        int          hold;
        logic [31:0] es, ea, ed;
        logic        et;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    uart_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_en        (cmd_en),
        .cmd_command   (cmd_command),
        .cmd_address   (cmd_address),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .rsp_valid     (rsp_valid),
        .rsp_timeout   (rsp_timeout),
        .rsp_status    (rsp_status),
        .rsp_address   (rsp_address),
        .rsp_data      (rsp_data),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .uart_tx_busy  (uart_tx_busy),
        .uart_received (uart_received),
        .uart_rx_byte  (uart_rx_byte)
    );

    // Byte-level uart core: busy rises the cycle after a transmit pulse and
    // stays up for TX_LEN cycles; every accepted byte is logged.
    initial begin
        forever begin
            @(negedge clk);
            uart_tx_busy = busy_hold || (busy_left > 0);
            if (busy_left > 0) busy_left--;
            #1;
            if (uart_transmit === 1'b1) begin
                tx_log.push_back(uart_tx_byte);
                if (uart_tx_busy) tx_overlap++;
                busy_left = TX_LEN;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Byte i of a packet made of three big-endian words.
    function automatic logic [7:0] pkt_byte(input logic [31:0] w0, w1, w2, input int i);
        logic [31:0] w;
        int sh;
        case (i / 4)
            0:       w = w0;
            1:       w = w1;
            default: w = w2;
        endcase
        sh = 8 * (3 - (i % 4));
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int         cyc;
        int         k;
        int         bad;
        logic       early;
        logic [7:0] b0;
        logic [7:0] got;

        @(negedge clk);
        tx_log.delete();
        tx_overlap = 0;
        #2;
        check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_command = v.c;
        cmd_address = v.a;
        cmd_data    = v.d;
        cmd_en      = 1'b1;
        if (v.hold > 0) busy_hold = 1'b1;

        @(negedge clk);
        cmd_en      = 1'b0;
        cmd_command = $urandom;
        cmd_address = $urandom;
        cmd_data    = $urandom;
        #2;
        check({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
        b0 = pkt_byte(v.c, v.a, v.d, 0);
        if (v.hold > 0) begin
            bad = 0;
            for (int i = 0; i < v.hold; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    #2;
                end
                if (uart_transmit !== 1'b0 || uart_tx_byte !== b0) bad++;
            end
            check({tag, "_hold_quiet_stable"}, 32'(bad), 32'd0);
            busy_hold = 1'b0;
        end else if (!uart_tx_busy) begin
            check({tag, "_first_tx_latency"}, 32'(uart_transmit), 32'd1);
        end

        cyc = 0;
        while (tx_log.size() < NBYTES && cyc < 2000) begin
            @(negedge clk);
            if (v.noise) begin
                cmd_en        = 1'($urandom_range(0, 1));
                uart_received = 1'($urandom_range(0, 1));
                uart_rx_byte  = 8'($urandom);
                cmd_command   = $urandom;
            end
            #2;
            cyc++;
        end
        check({tag, "_tx_count"}, 32'(tx_log.size()), 32'(NBYTES));
        @(negedge clk);
        cmd_en        = 1'b0;
        uart_received = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            check($sformatf("%s_tx_byte%0d", tag, i), 32'(got), 32'(pkt_byte(v.c, v.a, v.d, i)));
        end
        check({tag, "_tx_while_busy"}, 32'(tx_overlap), 32'd0);
        repeat (8) @(negedge clk);

        early = 1'b0;
        for (int i = 0; i < v.n_rx; i++) begin
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk);
                cmd_en        = v.noise && ($urandom_range(0, 2) == 0);
                uart_received = 1'b0;
                #2;
                if (rsp_valid) early = 1'b1;
            end
            @(negedge clk);
            cmd_en        = 1'b0;
            uart_received = 1'b1;
            uart_rx_byte  = pkt_byte(v.rx[95:64], v.rx[63:32], v.rx[31:0], i);
            #2;
            if (rsp_valid) early = 1'b1;
        end
        @(negedge clk);
        uart_received = 1'b0;
        cmd_en        = 1'b0;
        #2;
        check({tag, "_no_early_valid"}, 32'(early), 32'd0);
        if (v.n_rx >= NBYTES) begin
            check({tag, "_rsp_latency"}, 32'(rsp_valid), 32'd1);
        end else begin
            k = 1;
            while (!rsp_valid && k < 300) begin
                @(negedge clk);
                #2;
                k++;
            end
            check({tag, "_timeout_cycles"}, 32'(k), 32'(TMO));
        end
        check({tag, "_status"}, rsp_status, v.es);
        check({tag, "_address"}, rsp_address, v.ea);
        check({tag, "_data"}, rsp_data, v.ed);
        check({tag, "_timeout_flag"}, 32'(rsp_timeout), 32'(v.et));
        @(negedge clk);
        #2;
        check({tag, "_valid_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_no_second_packet"}, 32'(tx_log.size()), 32'(NBYTES));
    endtask

    initial begin
        vec_t        v;
        int          cyc;
        logic [7:0]  b;
        logic [31:0] w[3];

        rst           = 1'b0;
        cmd_en        = 1'b0;
        cmd_command   = '0;
        cmd_address   = '0;
        cmd_data      = '0;
        uart_received = 1'b0;
        uart_rx_byte  = '0;

        repeat (3) @(negedge clk);
        #2;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("reset_status", rsp_status, 32'd0);
        check("reset_transmit", 32'(uart_transmit), 32'd0);
        check("reset_tx_byte", 32'(uart_tx_byte), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        tbl[0] = '{32'h00000001, 32'h00000010, 32'hDEADBEEF, 96'h00000005_00000010_12345678,
                   12, 1'b0, 0, 32'h00000005, 32'h00000010, 32'h12345678, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 96'h80000000_FFFFFFFF_00000001,
                   12, 1'b0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 96'h0000CAFE_0000BEEF_DEAD0000,
                   12, 1'b1, 0, 32'h0000CAFE, 32'h0000BEEF, 32'hDEAD0000, 1'b0};
        tbl[3] = '{32'hC0DE0001, 32'h00000400, 32'h55AA55AA, 96'h00000000_00000400_55AA55AA,
                   12, 1'b0, 50, 32'h00000000, 32'h00000400, 32'h55AA55AA, 1'b0};
        tbl[4] = '{32'h00000002, 32'h00000020, 32'h00000000, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF,
                   5, 1'b0, 0, 32'h00000000, 32'h00000400, 32'h55AA55AA, 1'b1};
        tbl[5] = '{32'h00000003, 32'h00000030, 32'h11111111, 96'h00000007_00000030_87654321,
                   12, 1'b1, 0, 32'h00000007, 32'h00000030, 32'h87654321, 1'b0};

        for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of the command packet.
        @(negedge clk);
        tx_log.delete();
        cmd_command = 32'hCAFEF00D;
        cmd_address = 32'h00000100;
        cmd_data    = 32'h00000200;
        cmd_en      = 1'b1;
        @(negedge clk);
        cmd_en = 1'b0;
        cyc = 0;
        while (tx_log.size() < 7 && cyc < 1000) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("rst_mid_reached_byte7", 32'(tx_log.size()), 32'd7);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_transmit", 32'(uart_transmit), 32'd0);
        check("rst_mid_tx_byte", 32'(uart_tx_byte), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_status", rsp_status, 32'd0);
        check("rst_mid_address", rsp_address, 32'd0);
        check("rst_mid_data", rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_mid_no_valid_after", 32'(rsp_valid), 32'd0);

        v = '{32'hCAFEF00D, 32'h00000100, 32'h00000200, 96'h00000001_00000100_0BADF00D,
              12, 1'b0, 0, 32'h00000001, 32'h00000100, 32'h0BADF00D, 1'b0};
        run_txn(v, "post_rst");

        for (int r = 0; r < 6; r++) begin
            v.c     = $urandom;
            v.a     = $urandom;
            v.d     = $urandom;
            v.n_rx  = NBYTES;
            v.noise = 1'($urandom_range(0, 1));
            v.hold  = 0;
            v.et    = 1'b0;
            v.rx    = '0;
            w[0] = '0; w[1] = '0; w[2] = '0;
            for (int i = 0; i < NBYTES; i++) begin
                b = 8'($urandom);
                v.rx = {v.rx[87:0], b};
                w[i / 4] = (w[i / 4] << 8) | 32'(b);
            end
            v.es = w[0];
            v.ea = w[1];
            v.ed = w[2];
            run_txn(v, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
